// File: rtl/exc_pkg.sv
// Shared definitions for the exception/return controller: state encoding,
// exception cause codes, default handler vector and counter width.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HANDLER = 2'b01,
    HALTED  = 2'b10,
    FAULT   = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_NESTED  = 2'b10;
  localparam logic [1:0] CAUSE_BADRTI  = 2'b11;

  localparam logic [15:0] DEFAULT_HANDLER_ADDR = 16'h0002;
  localparam int          CNT_W                = 16;

  // HALTED and FAULT both stop the machine until reset.
  function automatic logic is_stopped(input state_e st);
    return (st == HALTED) || (st == FAULT);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous active-low clear; parks at all-ones.
module sat_cnt
  import exc_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/return controller between decode and the fetch PC mux.
// Optional EXC_CNT_EN adds exc_count, a saturating count of accepted SIICs.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int                 ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]  HANDLER_ADDR = DEFAULT_HANDLER_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              siic,
  input  logic              rti,
  input  logic              err,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              halt_out,
  output logic              in_handler,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        exc_cause
`ifdef EXC_CNT_EN
  ,
  output logic [15:0]       exc_count
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic [1:0]        cause_q, cause_d;
  logic              redirect_q, redirect_d;
  logic              halt_q, halt_d;
  logic              in_handler_q, in_handler_d;

  // Events are decoded in priority order err > halt_req > siic > rti.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    rpc_d      = rpc_q;
    cause_d    = cause_q;
    redirect_d = 1'b0;

    if (valid_in && !is_stopped(state_q)) begin
      if (err) begin
        state_d = FAULT;
        cause_d = CAUSE_ILLEGAL;
      end else if (halt_req) begin
        state_d = HALTED;
      end else if (siic) begin
        if (state_q == RUN) begin
          epc_d      = pc_next;
          rpc_d      = HANDLER_ADDR;
          redirect_d = 1'b1;
          state_d    = HANDLER;
        end else begin
          state_d = FAULT;
          cause_d = CAUSE_NESTED;
        end
      end else if (rti) begin
        if (state_q == HANDLER) begin
          rpc_d      = epc_q;
          redirect_d = 1'b1;
          state_d    = RUN;
        end else begin
          state_d = FAULT;
          cause_d = CAUSE_BADRTI;
        end
      end
    end

    halt_d       = is_stopped(state_d);
    in_handler_d = (state_d == HANDLER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      epc_q        <= '0;
      rpc_q        <= '0;
      cause_q      <= CAUSE_NONE;
      redirect_q   <= 1'b0;
      halt_q       <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      rpc_q        <= rpc_d;
      cause_q      <= cause_d;
      redirect_q   <= redirect_d;
      halt_q       <= halt_d;
      in_handler_q <= in_handler_d;
    end
  end

  // Flush shares the redirect register so the two pulses can never skew.
  assign redirect    = redirect_q;
  assign flush       = redirect_q;
  assign redirect_pc = rpc_q;
  assign halt_out    = halt_q;
  assign in_handler  = in_handler_q;
  assign epc         = epc_q;
  assign exc_cause   = cause_q;

`ifdef EXC_CNT_EN
  logic siic_accept;
  assign siic_accept = redirect_d && (state_q == RUN);

  sat_cnt #(
    .W(16)
  ) u_sat_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .inc  (siic_accept),
    .count(exc_count)
  );
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus a randomized run
// against an event-level reference model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, siic, rti, err, halt_req;
  logic [15:0] pc_next;
  logic        redirect, flush, halt_out, in_handler;
  logic [15:0] redirect_pc, epc;
  logic [1:0]  exc_cause;
`ifdef EXC_CNT_EN
  logic [15:0] exc_count;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  logic [37:0] obs, want;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .siic       (siic),
    .rti        (rti),
    .err        (err),
    .halt_req   (halt_req),
    .pc_next    (pc_next),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .flush      (flush),
    .halt_out   (halt_out),
    .in_handler (in_handler),
    .epc        (epc),
    .exc_cause  (exc_cause)
`ifdef EXC_CNT_EN
    ,
    .exc_count  (exc_count)
`endif
  );

  // Drive one cycle of inputs, take the edge, then sample just after it.
  task automatic applyStimulus(input logic rstN, input logic v, input logic s,
                               input logic r, input logic e, input logic h,
                               input logic [15:0] pc);
    rst_n = rstN; valid_in = v; siic = s; rti = r; err = e; halt_req = h;
    pc_next = pc;
    @(posedge clk);
    #1;
    obs = {redirect, flush, halt_out, in_handler, redirect_pc, epc, exc_cause};
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    want = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL reset_state: got %h want %h", obs, want); end
  endtask

  task automatic test_siic_rti();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
    want = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0040, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL siic_enter: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    want = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0040, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL siic_pulse_end: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0090);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0040, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL rti_return: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    want = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0040, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL rti_pulse_end: got %h want %h", obs, want); end
  endtask

  // Continues from RUN with epc=0040 left by test_siic_rti.
  task automatic test_bad_rti();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0040, 2'b11};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL bad_rti: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL fault_absorbs_siic: got %h want %h", obs, want); end
  endtask

  task automatic test_nested();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0040, 2'b10};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL nested_siic: got %h want %h", obs, want); end
  endtask

  task automatic test_priority();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0200);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b01};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL err_priority: got %h want %h", obs, want); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0300);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL halt_only: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0400);
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL halted_absorbs_err: got %h want %h", obs, want); end
  endtask

  task automatic test_valid_gate_and_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0500);
    want = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL valid_gate: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    want = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL wrap_pc_zero: got %h want %h", obs, want); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    want = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL reset_in_pulse: got %h want %h", obs, want); end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    want = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hFFFE, 2'b00};
    nCompared++;
    if (obs !== want) begin nMismatched++; $display("[TB] FAIL max_pc: got %h want %h", obs, want); end
  endtask

`ifdef EXC_CNT_EN
  task automatic test_count();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0600);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    nCompared++;
    if (exc_count !== 16'd3) begin nMismatched++; $display("[TB] FAIL count_three: got %0d want 3", exc_count); end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    nCompared++;
    if (exc_count !== 16'd3) begin nMismatched++; $display("[TB] FAIL count_after_fault: got %0d want 3", exc_count); end
  endtask
`endif

  // Reference model: mode 0 running, 1 in handler, 2 stopped (halt or fault).
  task automatic test_random();
    int          mMode;
    logic [15:0] mEpc, mRpc;
    logic [1:0]  mCause;
    logic        mRedir;
    int          mCount;
    logic        rN, v, s, r, e, h;
    logic [15:0] pc;
    mMode = 0; mEpc = 0; mRpc = 0; mCause = 0; mRedir = 0; mCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      rN = ($urandom_range(0, 39) != 0);
      v  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      e  = ($urandom_range(0, 11) == 0);
      h  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       pc = 16'hFFFE;
        1:       pc = 16'h0000;
        default: pc = 16'($urandom);
      endcase
      mRedir = 1'b0;
      if (!rN) begin
        mMode = 0; mEpc = 0; mRpc = 0; mCause = 0; mCount = 0;
      end else if (v && mMode != 2) begin
        if (e) begin
          mMode = 2; mCause = 2'b01;
        end else if (h) begin
          mMode = 2;
        end else if (s) begin
          if (mMode == 0) begin
            mEpc = pc; mRpc = 16'h0002; mRedir = 1'b1; mMode = 1;
            if (mCount < 65535) mCount++;
          end else begin
            mMode = 2; mCause = 2'b10;
          end
        end else if (r) begin
          if (mMode == 1) begin
            mRpc = mEpc; mRedir = 1'b1; mMode = 0;
          end else begin
            mMode = 2; mCause = 2'b11;
          end
        end
      end
      applyStimulus(rN, v, s, r, e, h, pc);
      want = {mRedir, mRedir, (mMode == 2), (mMode == 1), mRpc, mEpc, mCause};
      nCompared++;
      if (obs !== want) begin
        nMismatched++;
        $display("[TB] FAIL random_cycle_%0d: got %h want %h", i, obs, want);
      end
`ifdef EXC_CNT_EN
      nCompared++;
      if (exc_count !== 16'(mCount)) begin
        nMismatched++;
        $display("[TB] FAIL random_count_%0d: got %0d want %0d", i, exc_count, mCount);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; siic = 1'b0; rti = 1'b0; err = 1'b0;
    halt_req = 1'b0; pc_next = 16'h0000;
    #2;
    test_reset();
    test_siic_rti();
    test_bad_rti();
    test_nested();
    test_priority();
    test_valid_gate_and_reset();
`ifdef EXC_CNT_EN
    test_count();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
